// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: Funct3 access codes,
// FSM state encoding and small decode helpers used by the top level.
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Unsigned variants exist only for loads; everything else is illegal.
   function automatic logic f3Illegal(input logic isStore, input logic [2:0] f3);
      logic illegal;
      case (f3)
         F3_LB, F3_LH, F3_LW: illegal = 1'b0;
         F3_LBU, F3_LHU:      illegal = isStore;
         default:             illegal = 1'b1;
      endcase
      return illegal;
   endfunction

   // Halves must sit on an even byte, words on a 4-byte boundary.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
      logic bad;
      case (f3[1:0])
         2'b01:   bad = lane[0];
         2'b10:   bad = (lane != 2'b00);
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: builds the store byte-enables and the
// merged word to write back, and extracts/extends the addressed load lane.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_lane,
   input  logic [31:0] i_storeData,
   input  logic [31:0] i_memWord,
   output logic [3:0]  o_byteEn,
   output logic [31:0] o_mergedWord,
   output logic [31:0] o_loadData
);

   logic [31:0] w_lanedData;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Replicate right-aligned store data across lanes and pick the enables.
   always_comb begin
      o_byteEn    = 4'b0000;
      w_lanedData = 32'd0;
      case (i_funct3[1:0])
         2'b00: begin
            o_byteEn    = 4'b0001 << i_lane;
            w_lanedData = {4{i_storeData[7:0]}};
         end
         2'b01: begin
            o_byteEn    = i_lane[1] ? 4'b1100 : 4'b0011;
            w_lanedData = {2{i_storeData[15:0]}};
         end
         default: begin
            o_byteEn    = 4'b1111;
            w_lanedData = i_storeData;
         end
      endcase
   end

   // Keep untouched lanes from the current memory word.
   always_comb begin
      o_mergedWord = i_memWord;
      for (int i = 0; i < 4; i++) begin
         if (o_byteEn[i]) begin
            o_mergedWord[8*i +: 8] = w_lanedData[8*i +: 8];
         end
      end
   end

   assign w_byte = i_memWord[{i_lane, 3'b000} +: 8];
   assign w_half = i_memWord[{i_lane[1], 4'b0000} +: 16];

   // Sign- or zero-extend the addressed lane according to the access code.
   always_comb begin
      o_loadData = 32'd0;
      case (i_funct3)
         F3_LB:   o_loadData = {{24{w_byte[7]}}, w_byte};
         F3_LH:   o_loadData = {{16{w_half[15]}}, w_half};
         F3_LW:   o_loadData = i_memWord;
         F3_LBU:  o_loadData = {24'd0, w_byte};
         F3_LHU:  o_loadData = {16'd0, w_half};
         default: o_loadData = 32'd0;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Single-port data memory with a fixed-latency request/ack handshake.
// A request is latched in IDLE, held for WAIT_STATES cycles, then answered
// in a one-cycle RESP state where stores commit and loads return data.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 128,
   parameter int WAIT_STATES = 1
)
(
   input  logic        clock,
   input  logic        Reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] Address,
   input  logic [2:0]  Funct3,
   input  logic [31:0] WriteData,
   output logic        busy,
   output logic        ack,
   output logic        err,
   output logic [31:0] ReadData
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_START = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t      r_state;
   state_t      w_nextState;
   logic [3:0]  r_cnt;
   logic        r_we;
   logic [31:0] r_addr;
   logic [2:0]  r_funct3;
   logic [31:0] r_wdata;

   logic [31:0] r_mem [DEPTH_WORDS];

   logic              w_accept;
   logic [IDX_W-1:0]  w_index;
   logic              w_outOfRange;
   logic              w_fault;
   logic              w_doWrite;
   logic [31:0]       w_memWord;
   logic [3:0]        w_byteEn;
   logic [31:0]       w_mergedWord;
   logic [31:0]       w_loadData;

   assign w_accept = (r_state == ST_IDLE) && req;

   // Next-state logic; zero wait states skips straight to RESP.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req) begin
               w_nextState = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_nextState = ST_RESP;
            end
         end
         ST_RESP: w_nextState = ST_IDLE;
         default: w_nextState = ST_IDLE;
      endcase
   end

   // State register; reset abandons any in-flight request.
   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Request capture and wait-state down-counter.
   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         r_cnt    <= 4'd0;
         r_we     <= 1'b0;
         r_addr   <= 32'd0;
         r_funct3 <= 3'd0;
         r_wdata  <= 32'd0;
      end else if (w_accept) begin
         r_cnt    <= CNT_START;
         r_we     <= we;
         r_addr   <= Address;
         r_funct3 <= Funct3;
         r_wdata  <= WriteData;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   assign w_index      = r_addr[IDX_W+1:2];
   assign w_outOfRange = |r_addr[31:IDX_W+2];
   assign w_fault      = w_outOfRange
                       | f3Illegal(r_we, r_funct3)
                       | misaligned(r_funct3, r_addr[1:0]);
   assign w_memWord    = r_mem[w_index];
   assign w_doWrite    = (r_state == ST_RESP) && r_we && !w_fault;

   dmem_lane_align u_align (
      .i_funct3     (r_funct3),
      .i_lane       (r_addr[1:0]),
      .i_storeData  (r_wdata),
      .i_memWord    (w_memWord),
      .o_byteEn     (w_byteEn),
      .o_mergedWord (w_mergedWord),
      .o_loadData   (w_loadData)
   );

   // Storage array has no reset so it maps onto RAM; stores commit at the end of RESP.
   always_ff @(posedge clock) begin
      if (w_doWrite) begin
         for (int i = 0; i < 4; i++) begin
            if (w_byteEn[i]) begin
               r_mem[w_index][8*i +: 8] <= w_mergedWord[8*i +: 8];
            end
         end
      end
   end

   // Response outputs are gated by RESP so they are zero outside the ack cycle.
   always_comb begin
      busy     = (r_state != ST_IDLE);
      ack      = (r_state == ST_RESP);
      err      = ack && w_fault;
      ReadData = 32'd0;
      if (ack && !r_we && !w_fault) begin
         ReadData = w_loadData;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: one instance with one wait
// state and one with none, sharing clock and reset.
module tb_dmem_responder;
   import dmem_pkg::*;

   logic        clock = 1'b0;
   logic        Reset = 1'b0;

   logic        req1 = 1'b0, we1 = 1'b0;
   logic [31:0] addr1 = 32'd0, wd1 = 32'd0;
   logic [2:0]  f31 = 3'd0;
   logic        busy1, ack1, err1;
   logic [31:0] rd1;

   logic        req0 = 1'b0, we0 = 1'b0;
   logic [31:0] addr0 = 32'd0, wd0 = 32'd0;
   logic [2:0]  f30 = 3'd0;
   logic        busy0, ack0, err0;
   logic [31:0] rd0;

   bit          useZero = 1'b0;
   logic        obsBusy, obsAck, obsErr;
   logic [31:0] obsRd;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } expEntry_t;

   expEntry_t sbQueue[$];
   string     tagQueue[$];

   int compareCount = 0;
   int failCount    = 0;

   dmem_responder #(.DEPTH_WORDS(128), .WAIT_STATES(1)) dut1 (
      .clock(clock), .Reset(Reset), .req(req1), .we(we1), .Address(addr1),
      .Funct3(f31), .WriteData(wd1), .busy(busy1), .ack(ack1), .err(err1),
      .ReadData(rd1)
   );

   dmem_responder #(.DEPTH_WORDS(128), .WAIT_STATES(0)) dut0 (
      .clock(clock), .Reset(Reset), .req(req0), .we(we0), .Address(addr0),
      .Funct3(f30), .WriteData(wd0), .busy(busy0), .ack(ack0), .err(err0),
      .ReadData(rd0)
   );

   assign obsBusy = useZero ? busy0 : busy1;
   assign obsAck  = useZero ? ack0  : ack1;
   assign obsErr  = useZero ? err0  : err1;
   assign obsRd   = useZero ? rd0   : rd1;

   // Free-running clock.
   always #5 clock = ~clock;

   // Watchdog so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compareCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Drive one request into the selected instance and record its expected response.
   task automatic applyStimulus(input logic isStore, input logic [31:0] addr, input logic [2:0] f3,
                                input logic [31:0] wdata, input logic [31:0] expRd,
                                input logic expErr, input string tag);
      expEntry_t e;
      e.rdata = expRd;
      e.err   = expErr;
      e.lat   = useZero ? 1 : 2;
      sbQueue.push_back(e);
      tagQueue.push_back(tag);
      @(negedge clock);
      if (useZero) begin
         req0 = 1'b1; we0 = isStore; addr0 = addr; f30 = f3; wd0 = wdata;
      end else begin
         req1 = 1'b1; we1 = isStore; addr1 = addr; f31 = f3; wd1 = wdata;
      end
      @(posedge clock);
   endtask

   // Wait (bounded) for the ack, checking busy meanwhile, then score the response.
   task automatic checkOutput();
      expEntry_t e;
      string     tag;
      int        lat;
      bit        seen;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge clock);
         if (lat == 0) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
         lat++;
         if (obsAck) begin
            seen = 1'b1;
         end else begin
            checkVal("busyWhileWaiting", 32'(obsBusy), 32'd1);
         end
      end
      e   = sbQueue.pop_front();
      tag = tagQueue.pop_front();
      if (!seen) begin
         compareCount++;
         failCount++;
         $error("[TB] FAIL %s ackTimeout observed=noAck expected=ack", tag);
      end else begin
         checkVal({tag, ".latency"}, 32'(lat), 32'(e.lat));
         checkVal({tag, ".err"}, 32'(obsErr), 32'(e.err));
         checkVal({tag, ".ReadData"}, obsRd, e.rdata);
      end
   endtask

   initial begin
      int acks;
      expEntry_t e;
      string tag;

      $display("[TB] reset state");
      #12;
      checkVal("reset.busy1", 32'(busy1), 32'd0);
      checkVal("reset.ack1",  32'(ack1),  32'd0);
      checkVal("reset.err1",  32'(err1),  32'd0);
      checkVal("reset.rd1",   rd1,        32'd0);
      checkVal("reset.busy0", 32'(busy0), 32'd0);
      checkVal("reset.ack0",  32'(ack0),  32'd0);
      @(negedge clock);
      Reset = 1'b1;

      $display("[TB] one wait state: basic word and lane accesses");
      useZero = 1'b0;
      applyStimulus(1'b1, 32'h10, F3_SW, 32'hDEADBEEF, 32'h0, 1'b0, "SW@10");        checkOutput();
      applyStimulus(1'b0, 32'h10, F3_LW, 32'h0, 32'hDEADBEEF, 1'b0, "LW@10");         checkOutput();
      applyStimulus(1'b0, 32'h13, F3_LB, 32'h0, 32'hFFFFFFDE, 1'b0, "LB@13");         checkOutput();
      applyStimulus(1'b0, 32'h13, F3_LBU, 32'h0, 32'h000000DE, 1'b0, "LBU@13");       checkOutput();
      applyStimulus(1'b0, 32'h12, F3_LHU, 32'h0, 32'h0000DEAD, 1'b0, "LHU@12");       checkOutput();
      applyStimulus(1'b0, 32'h12, F3_LH, 32'h0, 32'hFFFFDEAD, 1'b0, "LH@12");         checkOutput();
      applyStimulus(1'b0, 32'h10, F3_LH, 32'h0, 32'hFFFFBEEF, 1'b0, "LH@10");         checkOutput();
      applyStimulus(1'b1, 32'h11, F3_SB, 32'hAAAAAA55, 32'h0, 1'b0, "SB@11");         checkOutput();
      applyStimulus(1'b0, 32'h10, F3_LW, 32'h0, 32'hDEAD55EF, 1'b0, "LWafterSB");     checkOutput();

      $display("[TB] one wait state: faults");
      applyStimulus(1'b0, 32'h11, F3_LH, 32'h0, 32'h0, 1'b1, "LHmisaligned");         checkOutput();
      applyStimulus(1'b0, 32'h12, F3_LW, 32'h0, 32'h0, 1'b1, "LWmisaligned");         checkOutput();
      applyStimulus(1'b0, 32'h200, F3_LW, 32'h0, 32'h0, 1'b1, "LWoutOfRange");        checkOutput();
      applyStimulus(1'b1, 32'h13, F3_SH, 32'h0000BEEF, 32'h0, 1'b1, "SHmisaligned");  checkOutput();
      applyStimulus(1'b1, 32'h10, F3_LBU, 32'h00000077, 32'h0, 1'b1, "storeUnsigned"); checkOutput();
      applyStimulus(1'b1, 32'h210, F3_SW, 32'h01010101, 32'h0, 1'b1, "SWoutOfRange"); checkOutput();
      applyStimulus(1'b0, 32'h10, F3_LW, 32'h0, 32'hDEAD55EF, 1'b0, "LWunchanged");   checkOutput();

      $display("[TB] one wait state: top word of the array");
      applyStimulus(1'b1, 32'h1FC, F3_SW, 32'h0BADCAFE, 32'h0, 1'b0, "SW@1FC");       checkOutput();
      applyStimulus(1'b0, 32'h1FE, F3_LHU, 32'h0, 32'h00000BAD, 1'b0, "LHU@1FE");     checkOutput();

      $display("[TB] req held high for six cycles");
      e.rdata = 32'hDEAD55EF; e.err = 1'b0; e.lat = 0;
      sbQueue.push_back(e); tagQueue.push_back("hold.first");
      sbQueue.push_back(e); tagQueue.push_back("hold.second");
      acks = 0;
      @(negedge clock);
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h10; f31 = F3_LW; wd1 = 32'h0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         if (c == 5) req1 = 1'b0;
         if (ack1) begin
            acks++;
            e   = sbQueue.pop_front();
            tag = tagQueue.pop_front();
            checkVal({tag, ".ReadData"}, rd1, e.rdata);
         end else if (c == 0 || c == 3) begin
            checkVal("hold.busyInWait", 32'(busy1), 32'd1);
         end else if (c == 2 || c == 5) begin
            checkVal("hold.idleGap", 32'(busy1), 32'd0);
         end
      end
      checkVal("hold.ackCount", 32'(acks), 32'd2);
      while (sbQueue.size() > 0) begin
         void'(sbQueue.pop_front());
         void'(tagQueue.pop_front());
      end

      $display("[TB] reset during a store wait state");
      applyStimulus(1'b1, 32'h20, F3_SW, 32'hCAFEF00D, 32'h0, 1'b0, "SW@20prior");    checkOutput();
      @(negedge clock);
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; f31 = F3_SW; wd1 = 32'h12345678;
      @(posedge clock);
      #2;
      req1  = 1'b0;
      Reset = 1'b0;
      #1;
      checkVal("abort.busy", 32'(busy1), 32'd0);
      checkVal("abort.ack",  32'(ack1),  32'd0);
      @(negedge clock);
      @(negedge clock);
      Reset = 1'b1;
      acks = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         if (ack1) acks++;
      end
      checkVal("abort.noAck", 32'(acks), 32'd0);
      applyStimulus(1'b0, 32'h20, F3_LW, 32'h0, 32'hCAFEF00D, 1'b0, "LW@20afterAbort"); checkOutput();

      $display("[TB] zero wait states");
      useZero = 1'b1;
      applyStimulus(1'b1, 32'h4, F3_SW, 32'h11223344, 32'h0, 1'b0, "ws0.SW@4");       checkOutput();
      applyStimulus(1'b0, 32'h4, F3_LW, 32'h0, 32'h11223344, 1'b0, "ws0.LW@4");       checkOutput();
      applyStimulus(1'b0, 32'h7, F3_LB, 32'h0, 32'h00000011, 1'b0, "ws0.LB@7");       checkOutput();
      applyStimulus(1'b0, 32'h4, 3'b011, 32'h0, 32'h0, 1'b1, "ws0.funct3_011");       checkOutput();
      applyStimulus(1'b0, 32'h4, 3'b110, 32'h0, 32'h0, 1'b1, "ws0.funct3_110");       checkOutput();

      @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
